// File: rtl/mips_pkg.sv
// Shared MIPS fetch-path definitions: instruction geometry, next-PC select
// codes and return-address-stack operation codes.
package mips_pkg;

   localparam int          INSTR_BYTES          = 4;
   localparam int          JUMP_INDEX_W         = 26;
   localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      PC_SEQ,
      PC_BRANCH,
      PC_JUMP,
      PC_JR
   } pc_sel_e;

   typedef enum logic [1:0] {
      RAS_NONE,
      RAS_PUSH,
      RAS_POP,
      RAS_REPLACE
   } ras_op_e;

   // Push and pop together on an empty stack degrades to a plain push.
   function automatic ras_op_e ras_decode(input logic push, input logic pop, input logic empty);
      ras_op_e op;
      op = RAS_NONE;
      if (push && pop) op = empty ? RAS_PUSH : RAS_REPLACE;
      else if (push)   op = RAS_PUSH;
      else if (pop)    op = RAS_POP;
      return op;
   endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Fetch-control bus between the control unit / branch comparator (master)
// and the program-counter block (slave).
interface pc_unit_if #(
   parameter int WIDTH     = 32,
   parameter int RAS_DEPTH = 4
);
   localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

   logic             stall;
   logic             branch_taken;
   logic [WIDTH-1:0] branch_offset;
   logic             jump_en;
   logic [25:0]      jump_index;
   logic             link_en;
   logic             jr_en;
   logic [WIDTH-1:0] jr_target;
   logic             ret_hint;

   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] pc_plus4;
   logic [WIDTH-1:0] ras_top;
   logic [CNT_W-1:0] ras_count;
   logic             misalign_err;
   logic             ras_underflow;

   modport master (
      output stall, branch_taken, branch_offset, jump_en, jump_index,
             link_en, jr_en, jr_target, ret_hint,
      input  pc, pc_plus4, ras_top, ras_count, misalign_err, ras_underflow
   );

   modport slave (
      input  stall, branch_taken, branch_offset, jump_en, jump_index,
             link_en, jr_en, jr_target, ret_hint,
      output pc, pc_plus4, ras_top, ras_count, misalign_err, ras_underflow
   );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack: the oldest entry is overwritten when full,
// and a pop on an empty stack raises a sticky underflow flag.
module pc_ras
   import mips_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_push_data,
   output logic [WIDTH-1:0] o_top,
   output logic [CNT_W-1:0] o_count,
   output logic             o_underflow
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_ptr;
   logic [CNT_W-1:0] r_count;
   logic             r_underflow;

   logic [WIDTH-1:0] w_mem_next [DEPTH];
   logic [PTR_W-1:0] w_ptr_next;
   logic [CNT_W-1:0] w_count_next;
   logic             w_underflow_next;
   logic [PTR_W-1:0] w_top_idx;
   logic             w_empty;
   ras_op_e          w_op;

   // r_ptr is the next free slot; DEPTH is a power of two so the index wraps.
   assign w_top_idx = r_ptr - PTR_W'(1);
   assign w_empty   = (r_count == '0);
   assign w_op      = ras_decode(i_push, i_pop, w_empty);

   always_comb begin
      // NOTE: every next-state signal gets a default first so no latch is inferred.
      w_mem_next       = r_mem;
      w_ptr_next       = r_ptr;
      w_count_next     = r_count;
      w_underflow_next = r_underflow;
      unique case (w_op)
         RAS_PUSH: begin
            w_mem_next[r_ptr] = i_push_data;
            w_ptr_next        = r_ptr + PTR_W'(1);
            if (r_count != CNT_W'(DEPTH)) w_count_next = r_count + CNT_W'(1);
         end
         RAS_POP: begin
            if (w_empty) begin
               w_underflow_next = 1'b1;
            end else begin
               w_ptr_next   = w_top_idx;
               w_count_next = r_count - CNT_W'(1);
            end
         end
         RAS_REPLACE: w_mem_next[w_top_idx] = i_push_data;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: entries are cleared on reset so ras_top is never X after a fresh start.
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_ptr       <= '0;
         r_count     <= '0;
         r_underflow <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only.
         r_mem       <= w_mem_next;
         r_ptr       <= w_ptr_next;
         r_count     <= w_count_next;
         r_underflow <= w_underflow_next;
      end
   end

   assign o_top       = w_empty ? '0 : r_mem[w_top_idx];
   assign o_count     = r_count;
   assign o_underflow = r_underflow;

endmodule

// File: rtl/pc_unit.sv
// MIPS program counter with internal next-PC selection (seq/branch/jump/jr),
// fetch stall, reset vector and a return-address stack for jal / jr $ra.
module pc_unit
   import mips_pkg::*;
#(
   parameter int               WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(RESET_VECTOR_DEFAULT),
   parameter int               RAS_DEPTH    = 4
) (
   input logic      clk,
   input logic      reset,
   pc_unit_if.slave pc_bus
);

   localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(28'hFFF_FFFF);

   logic [WIDTH-1:0] r_pc;
   logic             r_misalign;

   logic [WIDTH-1:0] w_pc_plus4;
   logic [WIDTH-1:0] w_jump_target;
   logic [WIDTH-1:0] w_branch_target;
   logic [WIDTH-1:0] w_jr_target;
   logic [WIDTH-1:0] w_next_pc;
   logic             w_misalign_next;
   logic             w_ras_push;
   logic             w_ras_pop;
   pc_sel_e          w_sel;

   assign w_pc_plus4      = r_pc + WIDTH'(INSTR_BYTES);
   assign w_branch_target = w_pc_plus4 + (pc_bus.branch_offset << 2);
   assign w_jr_target     = {pc_bus.jr_target[WIDTH-1:2], 2'b00};
   // The jump keeps the upper bits of pc+4 above the 28-bit region.
   assign w_jump_target   = (w_pc_plus4 & ~LOW_MASK)
                          | WIDTH'({pc_bus.jump_index[JUMP_INDEX_W-1:0], 2'b00});

   always_comb begin
      w_sel = PC_SEQ;
      if (pc_bus.jr_en)             w_sel = PC_JR;
      else if (pc_bus.jump_en)      w_sel = PC_JUMP;
      else if (pc_bus.branch_taken) w_sel = PC_BRANCH;
   end

   always_comb begin
      w_next_pc       = r_pc;
      w_misalign_next = r_misalign;
      if (!pc_bus.stall) begin
         unique case (w_sel)
            PC_JR: begin
               w_next_pc = w_jr_target;
               if (pc_bus.jr_target[1:0] != 2'b00) w_misalign_next = 1'b1;
            end
            PC_JUMP:   w_next_pc = w_jump_target;
            PC_BRANCH: w_next_pc = w_branch_target;
            default:   w_next_pc = w_pc_plus4;
         endcase
      end
   end

   // link_en only means something alongside a jump (jal / jalr).
   assign w_ras_push = !pc_bus.stall && pc_bus.link_en && (pc_bus.jump_en || pc_bus.jr_en);
   assign w_ras_pop  = !pc_bus.stall && pc_bus.jr_en && pc_bus.ret_hint;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc       <= RESET_VECTOR;
         r_misalign <= 1'b0;
      end else begin
         r_pc       <= w_next_pc;
         r_misalign <= w_misalign_next;
      end
   end

   pc_ras #(
      .WIDTH (WIDTH),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk         (clk),
      .reset       (reset),
      .i_push      (w_ras_push),
      .i_pop       (w_ras_pop),
      .i_push_data (w_pc_plus4),
      .o_top       (pc_bus.ras_top),
      .o_count     (pc_bus.ras_count),
      .o_underflow (pc_bus.ras_underflow)
   );

   assign pc_bus.pc           = r_pc;
   assign pc_bus.pc_plus4     = w_pc_plus4;
   assign pc_bus.misalign_err = r_misalign;

endmodule
